branch_issue_scheduler: RTL and testbench
=========================================

Name: branch_issue_scheduler

Overview:
- Reservation-station scheduler dedicated to the single branch unit.
- Buffers DEPTH dispatched branch/JALR ops and tracks operand readiness from CDB wakeups.
- Each cycle it selects the oldest ready op in ROB order and issues it to branch_unit through a registered issue stage.
- Sits between rename/dispatch and branch_unit; a flush empties it.

Parameters:
- DEPTH, 4, number of RS entries (2..8).
- PHYS_REG_BITS, 7, physical register index width.
- ROB_BITS, 4, ROB tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch presents a branch op
- alloc_ready  out  1  at least one free entry
- alloc_pc / alloc_imm  in  32 / 32  PC; immediate (funct3 in bits [2:0] for BRANCH)
- alloc_alu_op  in  2  00 JALR, 01 BRANCH
- alloc_reg_write  in  1  op writes prd
- alloc_prd  in  PHYS_REG_BITS  destination physical register
- alloc_rob_tag  in  ROB_BITS  ROB tag
- alloc_prs1 / alloc_prs2  in  PHYS_REG_BITS  source physical registers
- alloc_rs1_rdy / alloc_rs2_rdy  in  1  source already available
- wakeup_valid  in  1  CDB broadcast valid
- wakeup_prd  in  PHYS_REG_BITS  broadcast register
- rob_head  in  ROB_BITS  oldest ROB tag, used for age
- unit_ready  in  1  branch_unit accepts an issue this cycle
- issue_en  out  1  registered issue valid
- issue_pc, issue_imm, issue_alu_op, issue_reg_write, issue_prd, issue_rob_tag, issue_prs1, issue_prs2  out  match alloc widths  registered issue payload
- flush  in  1  mispredict flush
- occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (rst_n low, asynchronous): all entry valid bits 0; issue_en 0; issue payload 0; occupancy 0; alloc_ready 1.
- alloc_ready is combinational: occupancy < DEPTH. An entry freed in the same cycle does not count as free until the next cycle.
- Allocation when alloc_valid && alloc_ready && !flush: write to the lowest-index free entry at the clock edge. A source is marked ready if any of these holds:
  - its alloc_rsN_rdy is 1;
  - its prs equals 0;
  - wakeup_valid && wakeup_prd == prs in the same cycle.
- alloc_valid while full: ignored; dispatch must hold the op.
- Wakeup: every valid entry whose prs1/prs2 equals wakeup_prd sets that ready bit at the edge. A wakeup of register 0 has no effect.
- Eligibility: entry valid and both ready bits set, as registered at the start of the cycle.
- Age = (rob_tag - rob_head) mod 2^ROB_BITS, unsigned. Select the eligible entry with minimum age. Tags are unique, so ties cannot occur.
- Issue stage (1-cycle latency):
  - If an eligible entry exists and (!issue_en || unit_ready), copy it into the issue register at the edge, set issue_en=1, and clear the entry's valid bit.
  - If issue_en && !unit_ready: hold the issue register unchanged and do not select.
  - If issue_en && unit_ready with no eligible entry: issue_en becomes 0.
- Occupancy updates the same edge: +1 on allocation, -1 on selection. Both together leave it unchanged.
- Flush (sync, highest priority): at the edge, clear all valid bits and issue_en, and set occupancy to 0. Allocation and wakeup in that cycle are discarded. alloc_ready reads 1 the cycle after.
- rst_n asserted mid-operation: immediate clear with the same reset values, regardless of clk.
- An entry is never issued twice. An entry allocated in cycle N is issued at the earliest at edge N+1, i.e. issue_en high in cycle N+1.

Optional Feature:
- Macro: BRANCH_SCHED_WAKEUP_BYPASS_EN.
- Defined: an entry whose last missing operand is woken in cycle N is eligible for selection in cycle N, with the wakeup compared combinationally. Wakeup-to-issue_en is 1 cycle.
- Undefined: the entry becomes eligible in cycle N+1. Wakeup-to-issue_en is 2 cycles.
- Allocation-time wakeup capture is identical in both builds.

Test Plan:
- Reset release, alloc BEQ (rob_tag 3, both rdy, pc 0x1000), unit_ready=1 -> issue_en=1 next cycle, issue_rob_tag=3, issue_pc=0x1000; occupancy 1 then 0.
- rob_head=14; alloc tags 1, 15, 0, all ready, same-cycle eligible -> issue order 15, 0, 1 (wrap-around age).
- Alloc JALR prs1=9 not ready; wakeup_prd=9 at cycle N -> issue_en at N+2 without the macro, N+1 with it.
- Fill 4 entries -> alloc_ready=0; a 5th alloc_valid is ignored; after one issue, alloc_ready=1 and the next alloc lands in the freed index.
- issue_en high, unit_ready=0 for 3 cycles -> payload stable, no entry dequeued; unit_ready=1 -> next oldest entry issued.
- 3 entries valid plus issue_en=1; flush with simultaneous alloc_valid and wakeup -> next cycle issue_en=0, occupancy=0, alloc_ready=1, no later issue of flushed tags.

Source files
------------

// File: rtl/branch_issue_scheduler.sv
// branch_issue_scheduler
//   Reservation station for the single branch unit. Holds up to DEPTH
//   dispatched BRANCH/JALR ops, tracks source readiness from CDB wakeups,
//   and each cycle moves the oldest ready op (age relative to rob_head)
//   into a registered issue stage feeding branch_unit. flush empties it.
//
// Build option:
//   BRANCH_SCHED_WAKEUP_BYPASS_EN - when defined, a same-cycle wakeup
//   counts toward eligibility combinationally (wakeup-to-issue_en = 1 cycle);
//   otherwise eligibility uses registered ready bits only (2 cycles).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   alloc_valid / alloc_ready  dispatch handshake (ready = occupancy < DEPTH)
//   alloc_*                    op payload, sources and their ready flags
//   wakeup_valid, wakeup_prd   CDB broadcast
//   rob_head                   oldest ROB tag, reference for age
//   unit_ready                 branch_unit accepts the issue register
//   issue_en, issue_*          registered issue valid and payload
//   flush                      mispredict flush, clears all state
//   occupancy                  number of valid entries
module branch_issue_scheduler #(
  parameter int DEPTH         = 4,
  parameter int PHYS_REG_BITS = 7,
  parameter int ROB_BITS      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [31:0]                alloc_pc,
  input  logic [31:0]                alloc_imm,
  input  logic [1:0]                 alloc_alu_op,
  input  logic                       alloc_reg_write,
  input  logic [PHYS_REG_BITS-1:0]   alloc_prd,
  input  logic [ROB_BITS-1:0]        alloc_rob_tag,
  input  logic [PHYS_REG_BITS-1:0]   alloc_prs1,
  input  logic [PHYS_REG_BITS-1:0]   alloc_prs2,
  input  logic                       alloc_rs1_rdy,
  input  logic                       alloc_rs2_rdy,
  input  logic                       wakeup_valid,
  input  logic [PHYS_REG_BITS-1:0]   wakeup_prd,
  input  logic [ROB_BITS-1:0]        rob_head,
  input  logic                       unit_ready,
  output logic                       issue_en,
  output logic [31:0]                issue_pc,
  output logic [31:0]                issue_imm,
  output logic [1:0]                 issue_alu_op,
  output logic                       issue_reg_write,
  output logic [PHYS_REG_BITS-1:0]   issue_prd,
  output logic [ROB_BITS-1:0]        issue_rob_tag,
  output logic [PHYS_REG_BITS-1:0]   issue_prs1,
  output logic [PHYS_REG_BITS-1:0]   issue_prs2,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic                     valid;
    logic                     rdy1;
    logic                     rdy2;
    logic [31:0]              pc;
    logic [31:0]              imm;
    logic [1:0]               alu_op;
    logic                     reg_write;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_BITS-1:0]      rob_tag;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
  } entry_t;

  entry_t              ent [DEPTH];
  entry_t              new_ent;
  logic                wake_hit;
  logic                alloc_fire;
  logic                alloc_found;
  logic [IDX_W-1:0]    alloc_idx;
  logic [DEPTH-1:0]    elig;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [ROB_BITS-1:0] best_age;
  logic [ROB_BITS-1:0] age;
  logic                sel_fire;

  // Register 0 is hardwired ready, so a broadcast of it never changes state.
  assign wake_hit    = wakeup_valid && (wakeup_prd != '0);
  assign alloc_ready = (occupancy < OCC_W'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready && !flush;

  // Lowest-index free entry.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ent[i].valid && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.rdy1      = alloc_rs1_rdy || (alloc_prs1 == '0) ||
                        (wake_hit && (wakeup_prd == alloc_prs1));
    new_ent.rdy2      = alloc_rs2_rdy || (alloc_prs2 == '0) ||
                        (wake_hit && (wakeup_prd == alloc_prs2));
    new_ent.pc        = alloc_pc;
    new_ent.imm       = alloc_imm;
    new_ent.alu_op    = alloc_alu_op;
    new_ent.reg_write = alloc_reg_write;
    new_ent.prd       = alloc_prd;
    new_ent.rob_tag   = alloc_rob_tag;
    new_ent.prs1      = alloc_prs1;
    new_ent.prs2      = alloc_prs2;
  end

  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef BRANCH_SCHED_WAKEUP_BYPASS_EN
      elig[i] = ent[i].valid &&
                (ent[i].rdy1 || (wake_hit && (ent[i].prs1 == wakeup_prd))) &&
                (ent[i].rdy2 || (wake_hit && (ent[i].prs2 == wakeup_prd)));
`else
      elig[i] = ent[i].valid && ent[i].rdy1 && ent[i].rdy2;
`endif
    end
  end

  // Oldest eligible entry: minimum (rob_tag - rob_head) modulo 2^ROB_BITS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    age       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age = ent[i].rob_tag - rob_head;
      if (elig[i] && (!sel_found || (age < best_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        best_age  = age;
      end
    end
  end

  assign sel_fire = sel_found && (!issue_en || unit_ready) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent[i].valid && wake_hit) begin
          if (ent[i].prs1 == wakeup_prd) ent[i].rdy1 <= 1'b1;
          if (ent[i].prs2 == wakeup_prd) ent[i].rdy2 <= 1'b1;
        end
        // Allocation targets a free slot and selection a valid one,
        // so the two never collide on the same index.
        if (sel_fire && (sel_idx == IDX_W'(i)))     ent[i].valid <= 1'b0;
        if (alloc_fire && (alloc_idx == IDX_W'(i))) ent[i] <= new_ent;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_en        <= 1'b0;
      issue_pc        <= '0;
      issue_imm       <= '0;
      issue_alu_op    <= '0;
      issue_reg_write <= 1'b0;
      issue_prd       <= '0;
      issue_rob_tag   <= '0;
      issue_prs1      <= '0;
      issue_prs2      <= '0;
    end else if (flush) begin
      issue_en <= 1'b0;
    end else if (sel_fire) begin
      issue_en        <= 1'b1;
      issue_pc        <= ent[sel_idx].pc;
      issue_imm       <= ent[sel_idx].imm;
      issue_alu_op    <= ent[sel_idx].alu_op;
      issue_reg_write <= ent[sel_idx].reg_write;
      issue_prd       <= ent[sel_idx].prd;
      issue_rob_tag   <= ent[sel_idx].rob_tag;
      issue_prs1      <= ent[sel_idx].prs1;
      issue_prs2      <= ent[sel_idx].prs2;
    end else if (unit_ready) begin
      issue_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else if (alloc_fire && !sel_fire) begin
      occupancy <= occupancy + 1'b1;
    end else if (!alloc_fire && sel_fire) begin
      occupancy <= occupancy - 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_issue_scheduler.sv
module tb_branch_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alloc_valid = 1'b0;
  logic        alloc_ready;
  logic [31:0] alloc_pc = '0;
  logic [31:0] alloc_imm = '0;
  logic [1:0]  alloc_alu_op = '0;
  logic        alloc_reg_write = 1'b0;
  logic [6:0]  alloc_prd = '0;
  logic [3:0]  alloc_rob_tag = '0;
  logic [6:0]  alloc_prs1 = '0;
  logic [6:0]  alloc_prs2 = '0;
  logic        alloc_rs1_rdy = 1'b0;
  logic        alloc_rs2_rdy = 1'b0;
  logic        wakeup_valid = 1'b0;
  logic [6:0]  wakeup_prd = '0;
  logic [3:0]  rob_head = '0;
  logic        unit_ready = 1'b0;
  logic        issue_en;
  logic [31:0] issue_pc;
  logic [31:0] issue_imm;
  logic [1:0]  issue_alu_op;
  logic        issue_reg_write;
  logic [6:0]  issue_prd;
  logic [3:0]  issue_rob_tag;
  logic [6:0]  issue_prs1;
  logic [6:0]  issue_prs2;
  logic        flush = 1'b0;
  logic [2:0]  occupancy;

`ifdef BRANCH_SCHED_WAKEUP_BYPASS_EN
  localparam int WAKE_LAT = 1;
`else
  localparam int WAKE_LAT = 2;
`endif

  branch_issue_scheduler #(.DEPTH(4), .PHYS_REG_BITS(7), .ROB_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pc(alloc_pc), .alloc_imm(alloc_imm), .alloc_alu_op(alloc_alu_op),
    .alloc_reg_write(alloc_reg_write), .alloc_prd(alloc_prd),
    .alloc_rob_tag(alloc_rob_tag), .alloc_prs1(alloc_prs1), .alloc_prs2(alloc_prs2),
    .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
    .wakeup_valid(wakeup_valid), .wakeup_prd(wakeup_prd),
    .rob_head(rob_head), .unit_ready(unit_ready),
    .issue_en(issue_en), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_alu_op(issue_alu_op), .issue_reg_write(issue_reg_write),
    .issue_prd(issue_prd), .issue_rob_tag(issue_rob_tag),
    .issue_prs1(issue_prs1), .issue_prs2(issue_prs2),
    .flush(flush), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // An issue is consumed when issue_en and unit_ready are both high at the edge.
  always @(negedge clk) begin
    if (rst_n && issue_en && unit_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_issue_tag", {28'b0, issue_rob_tag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("issue_rob_tag", {28'b0, issue_rob_tag}, {28'b0, e.tag});
        check("issue_pc", issue_pc, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] tag, input logic [31:0] pc);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    sb.push_back(e);
  endtask

  task automatic do_alloc(input logic [3:0] tag, input logic [31:0] pc, input logic [1:0] op,
                          input logic [6:0] p1, input logic r1, input logic [6:0] p2, input logic r2);
    alloc_valid     = 1'b1;
    alloc_rob_tag   = tag;
    alloc_pc        = pc;
    alloc_imm       = {29'b0, 3'b000};
    alloc_alu_op    = op;
    alloc_reg_write = (op == 2'b00);
    alloc_prd       = 7'd50 + {3'b0, tag};
    alloc_prs1      = p1;
    alloc_rs1_rdy   = r1;
    alloc_prs2      = p2;
    alloc_rs2_rdy   = r2;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int k = 0; k < max_cycles && sb.size() != 0; k++) @(posedge clk);
    #1;
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic seen;

    // Reset values
    @(negedge clk);
    check("rst_issue_en", issue_en, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_alloc_ready", alloc_ready, 1);
    step();
    rst_n = 1'b1;
    unit_ready = 1'b1;
    step();

    // Single BEQ: occupancy 1, then issued with occupancy 0
    push(4'd3, 32'h1000);
    do_alloc(4'd3, 32'h1000, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    @(negedge clk);
    check("t1_occ_after_alloc", occupancy, 1);
    check("t1_issue_en_early", issue_en, 0);
    @(negedge clk);
    check("t1_issue_en", issue_en, 1);
    check("t1_occ_after_issue", occupancy, 0);
    step();
    drain("t1_drain", 4);

    // Wrap-around age: head 14, tags 1,15,0 become ready together
    rob_head = 4'd14;
    do_alloc(4'd1,  32'h2004, 2'b01, 7'd5, 1'b0, 7'd0, 1'b0);
    do_alloc(4'd15, 32'h203C, 2'b01, 7'd5, 1'b0, 7'd0, 1'b0);
    do_alloc(4'd0,  32'h2000, 2'b01, 7'd5, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    check("t2_occ", occupancy, 3);
    check("t2_no_issue_before_wake", issue_en, 0);
    step();
    push(4'd15, 32'h203C);
    push(4'd0,  32'h2000);
    push(4'd1,  32'h2004);
    wakeup_valid = 1'b1;
    wakeup_prd   = 7'd5;
    step();
    wakeup_valid = 1'b0;
    drain("t2_drain", 12);

    // Wakeup-to-issue latency for a JALR waiting on prs1
    rob_head = 4'd0;
    do_alloc(4'd5, 32'h3000, 2'b00, 7'd9, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    check("t3_pre_wake_issue_en", issue_en, 0);
    step();
    push(4'd5, 32'h3000);
    wakeup_valid = 1'b1;
    wakeup_prd   = 7'd9;
    lat = cyc;
    step();
    wakeup_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      @(negedge clk);
      if (issue_en) begin
        seen = 1'b1;
        lat  = cyc - lat;
      end
    end
    check("t3_issue_seen", seen, 1);
    if (seen) check("t3_wake_latency", lat, WAKE_LAT);
    step();
    drain("t3_drain", 4);

    // Allocation-time wakeup capture
    push(4'd6, 32'h3100);
    wakeup_valid = 1'b1;
    wakeup_prd   = 7'd11;
    do_alloc(4'd6, 32'h3100, 2'b01, 7'd11, 1'b0, 7'd12, 1'b1);
    wakeup_valid = 1'b0;
    drain("t3b_alloc_wake_drain", 8);

    // Full, ignored 5th alloc, hold while unit not ready, refill freed slot
    unit_ready = 1'b0;
    for (int t = 0; t < 4; t++)
      do_alloc(4'(t), 32'h4000 + 32'(t * 4), 2'b01, 7'd20, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    check("t4_occ_full", occupancy, 4);
    check("t4_alloc_ready_full", alloc_ready, 0);
    step();
    do_alloc(4'd7, 32'h4070, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    @(negedge clk);
    check("t4_occ_after_ignored", occupancy, 4);
    step();
    for (int t = 0; t < 5; t++) push(4'(t), 32'h4000 + 32'(t * 4));
    wakeup_valid = 1'b1;
    wakeup_prd   = 7'd20;
    step();
    wakeup_valid = 1'b0;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_hold_issue_en", issue_en, 1);
      check("t5_hold_tag", {28'b0, issue_rob_tag}, 0);
      check("t5_hold_pc", issue_pc, 32'h4000);
      check("t5_hold_occ", occupancy, 3);
    end
    check("t5_alloc_ready_after_issue", alloc_ready, 1);
    step();
    do_alloc(4'd4, 32'h4010, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    @(negedge clk);
    check("t5_occ_refill", occupancy, 4);
    check("t5_still_held_tag", {28'b0, issue_rob_tag}, 0);
    step();
    unit_ready = 1'b1;
    drain("t5_drain", 14);
    step();

    // Flush with simultaneous alloc and wakeup
    unit_ready = 1'b0;
    do_alloc(4'd8,  32'h5020, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    do_alloc(4'd9,  32'h5024, 2'b01, 7'd30, 1'b0, 7'd2, 1'b1);
    do_alloc(4'd10, 32'h5028, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    do_alloc(4'd11, 32'h502C, 2'b01, 7'd30, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    check("t6_pre_issue_en", issue_en, 1);
    check("t6_pre_tag", {28'b0, issue_rob_tag}, 8);
    check("t6_pre_occ", occupancy, 3);
    step();
    flush        = 1'b1;
    wakeup_valid = 1'b1;
    wakeup_prd   = 7'd30;
    do_alloc(4'd12, 32'h5030, 2'b01, 7'd1, 1'b1, 7'd2, 1'b1);
    flush        = 1'b0;
    wakeup_valid = 1'b0;
    @(negedge clk);
    check("t6_issue_en", issue_en, 0);
    check("t6_occ", occupancy, 0);
    check("t6_alloc_ready", alloc_ready, 1);
    step();
    unit_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (issue_en) seen = 1'b1;
    end
    check("t6_no_reissue", seen, 0);
    step();
    push(4'd13, 32'h5034);
    do_alloc(4'd13, 32'h5034, 2'b00, 7'd1, 1'b1, 7'd0, 1'b0);
    drain("t6_post_flush_drain", 6);

    // Asynchronous reset mid-operation
    unit_ready = 1'b0;
    do_alloc(4'd2, 32'h6000, 2'b01, 7'd40, 1'b0, 7'd0, 1'b0);
    @(negedge clk);
    check("t7_occ_before_reset", occupancy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_async_occ", occupancy, 0);
    check("t7_async_alloc_ready", alloc_ready, 1);
    check("t7_async_issue_en", issue_en, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
